// File: rtl/md_unit_pkg.sv
// ---------------------------------------------------------------------------
// md_unit_pkg
// Shared definitions for the multiply/divide unit: the md op-code constants
// (also used by the decoder and the stall logic), the FSM state type, the
// shadow-result record and the behavioural arithmetic done at issue time.
// ---------------------------------------------------------------------------
package md_unit_pkg;

  // md op codes; 3'd6 and 3'd7 are reserved and act as no-ops
  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  // Result computed at issue and held until the latency counter expires.
  // wr is clear for a divide by zero so HI/LO are left untouched.
  typedef struct packed {
    logic        wr;
    logic [31:0] hi;
    logic [31:0] lo;
  } md_result_t;

  // True for the ops that occupy the unit for several cycles.
  function automatic logic md_is_long(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) ||
           (op == MD_DIV)  || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // Behavioural multiply/divide. Signed division works on magnitudes so the
  // 0x80000000 / -1 case falls out naturally: |0x80000000| is 0x80000000 as
  // an unsigned value, the quotient sign is positive, giving 0x80000000, r=0.
  function automatic md_result_t md_compute(input logic [2:0]  op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    md_result_t  r;
    logic [63:0] p;
    logic [31:0] ma;
    logic [31:0] mb;
    logic [31:0] q;
    logic [31:0] rm;
    r  = '0;
    p  = '0;
    ma = '0;
    mb = '0;
    q  = '0;
    rm = '0;
    case (op)
      MD_MULT: begin
        // low 64 bits of the sign-extended product are the signed product
        p    = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        r.wr = 1'b1;
        r.hi = p[63:32];
        r.lo = p[31:0];
      end
      MD_MULTU: begin
        p    = {32'b0, a} * {32'b0, b};
        r.wr = 1'b1;
        r.hi = p[63:32];
        r.lo = p[31:0];
      end
      MD_DIV: begin
        if (b != '0) begin
          ma   = a[31] ? -a : a;
          mb   = b[31] ? -b : b;
          q    = ma / mb;
          rm   = ma % mb;
          r.wr = 1'b1;
          r.lo = (a[31] ^ b[31]) ? -q : q;
          r.hi = a[31] ? -rm : rm;
        end
      end
      MD_DIVU: begin
        if (b != '0) begin
          r.wr = 1'b1;
          r.lo = a / b;
          r.hi = a % b;
        end
      end
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/md_unit.sv
// ---------------------------------------------------------------------------
// md_unit
// MIPS-style HI/LO multiply/divide unit. The result of mult/multu/div/divu is
// computed at issue into shadow registers and only becomes visible on HI/LO
// after a fixed latency, during which busy is asserted and further starts are
// ignored. mthi/mtlo write HI/LO directly at the next edge.
//
// Parameters
//   MULT_CYCLES  busy duration of mult/multu (>= 1)
//   DIV_CYCLES   busy duration of div/divu   (>= 1)
// Ports
//   clk          clock, rising edge
//   rst          asynchronous reset, active low
//   start        an md instruction is issued this cycle
//   op           md op code (MD_* in md_unit_pkg)
//   src_a        rs operand (forwarded)
//   src_b        rt operand (forwarded)
//   busy         registered, high while a mult/div is in flight
//   hi, lo       architectural HI/LO registers
// ---------------------------------------------------------------------------
module md_unit
  import md_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  md_state_e          state;
  logic [CNT_W-1:0]   cnt;
  md_result_t         shadow;
  md_result_t         issue_res;
  logic [CNT_W-1:0]   issue_len;

  always_comb begin
    issue_res = md_compute(op, src_a, src_b);
    issue_len = md_is_div(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      busy   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      cnt    <= '0;
      shadow <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (md_is_long(op)) begin
              shadow <= issue_res;
              cnt    <= issue_len;
              state  <= ST_BUSY;
              busy   <= 1'b1;
            end else if (op == MD_MTHI) begin
              hi <= src_a;
            end else if (op == MD_MTLO) begin
              lo <= src_a;
            end
          end
        end
        ST_BUSY: begin
          // Completing at cnt<=1 (not ==1) keeps a zero load from wrapping.
          if (cnt <= CNT_W'(1)) begin
            if (shadow.wr) begin
              hi <= shadow.hi;
              lo <= shadow.lo;
            end
            cnt   <= '0;
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int tests;
  int failed;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .src_a (src_a),
    .src_b (src_b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_cyc;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: MIPS HI/LO semantics with 64-bit arithmetic.
  task automatic model(input logic [2:0] mop, input logic [31:0] a, input logic [31:0] b,
                       inout logic [31:0] mh, inout logic [31:0] ml, output int cyc);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    cyc = 0;
    case (mop)
      3'd0: begin p = sa * sb; mh = p[63:32]; ml = p[31:0]; cyc = 5; end
      3'd1: begin p = {32'b0, a} * {32'b0, b}; mh = p[63:32]; ml = p[31:0]; cyc = 5; end
      3'd2: begin
        cyc = 10;
        if (b != 0) begin
          q = sa / sb; r = sa % sb;
          p = q; ml = p[31:0];
          p = r; mh = p[31:0];
        end
      end
      3'd3: begin
        cyc = 10;
        if (b != 0) begin ml = a / b; mh = a % b; end
      end
      3'd4: mh = a;
      3'd5: ml = a;
      default: ;
    endcase
  endtask

  // Issue one op, then count busy cycles while hammering start with random
  // ops (which must be ignored) and watching that HI/LO hold.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int cyc, output logic hold_ok);
    logic [31:0] ph, pl;
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    ph = hi; pl = lo;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    hold_ok = 1'b1;
    while (busy === 1'b1 && cyc < 200) begin
      cyc++;
      if (hi !== ph || lo !== pl) hold_ok = 1'b0;
      start = 1'($urandom_range(0, 1));
      op    = 3'($urandom_range(0, 7));
      src_a = $urandom;
      src_b = $urandom;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] s[5];
    s[0] = 32'h8000_0000; s[1] = 32'hFFFF_FFFF; s[2] = 32'h0;
    s[3] = 32'h7FFF_FFFF; s[4] = 32'h1;
    if ($urandom_range(0, 3) == 0) return s[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  initial begin
    int cyc;
    int mcyc;
    int n;
    logic hold;
    logic [31:0] mh, ml, ra, rb, pl;
    logic [2:0] rop;

    tests = 0; failed = 0;
    rst = 1'b1; start = 1'b0; op = '0; src_a = '0; src_b = '0;

    vecs[0]  = '{3'd4, 32'h1234_5678, 32'h0,         32'h1234_5678, 32'h0000_0000, 0};
    vecs[1]  = '{3'd5, 32'hCAFE_BABE, 32'h0,         32'h1234_5678, 32'hCAFE_BABE, 0};
    vecs[2]  = '{3'd6, 32'h0000_0001, 32'h2,         32'h1234_5678, 32'hCAFE_BABE, 0};
    vecs[3]  = '{3'd0, 32'hFFFF_FFFE, 32'h3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
    vecs[4]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5};
    vecs[5]  = '{3'd2, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    vecs[6]  = '{3'd3, 32'h0000_0007, 32'h0,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    vecs[7]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10};
    vecs[8]  = '{3'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10};
    vecs[9]  = '{3'd3, 32'hFFFF_FFFF, 32'h10,        32'h0000_000F, 32'h0FFF_FFFF, 10};
    vecs[10] = '{3'd2, 32'h0000_0000, 32'h0,         32'h0000_000F, 32'h0FFF_FFFF, 10};
    vecs[11] = '{3'd7, 32'hDEAD_BEEF, 32'h1,         32'h0000_000F, 32'h0FFF_FFFF, 0};

    // reset state, asserted asynchronously
    #2 rst = 1'b0;
    #1;
    check("reset_busy", {31'b0, busy}, 32'h0);
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // directed table
    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, cyc, hold);
      check($sformatf("vec%0d_cycles", i), 32'(cyc), 32'(vecs[i].exp_cyc));
      check($sformatf("vec%0d_hi", i), hi, vecs[i].exp_hi);
      check($sformatf("vec%0d_lo", i), lo, vecs[i].exp_lo);
      check($sformatf("vec%0d_hold", i), {31'b0, hold}, 32'h1);
    end

    // randomized against the model
    mh = 32'h0000_000F; ml = 32'h0FFF_FFFF;
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = pick_operand();
      rb  = ($urandom_range(0, 5) == 0) ? 32'h0 : pick_operand();
      model(rop, ra, rb, mh, ml, mcyc);
      run_op(rop, ra, rb, cyc, hold);
      check($sformatf("rnd%0d_cycles op%0d", i, rop), 32'(cyc), 32'(mcyc));
      check($sformatf("rnd%0d_hi op%0d a=%h b=%h", i, rop, ra, rb), hi, mh);
      check($sformatf("rnd%0d_lo op%0d a=%h b=%h", i, rop, ra, rb), lo, ml);
      check($sformatf("rnd%0d_hold", i), {31'b0, hold}, 32'h1);
    end

    // MTHI then back-to-back MULT; MTLO during BUSY must be dropped
    @(negedge clk);
    pl = lo;
    start = 1'b1; op = 3'd4; src_a = 32'h1234_5678; src_b = '0;
    @(negedge clk);
    check("seq33_mthi_hi", hi, 32'h1234_5678);
    op = 3'd0; src_a = 32'h2; src_b = 32'h3;
    @(negedge clk);
    op = 3'd5; src_a = 32'hDEAD_0000;
    cyc = 0; hold = 1'b1;
    while (busy === 1'b1 && cyc < 200) begin
      cyc++;
      if (hi !== 32'h1234_5678 || lo !== pl) hold = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    check("seq33_cycles", 32'(cyc), 32'd5);
    check("seq33_hold", {31'b0, hold}, 32'h1);
    check("seq33_hi", hi, 32'h0);
    check("seq33_lo", lo, 32'h6);

    // reset in the middle of a DIV aborts it
    run_op(3'd4, 32'hAAAA_5555, 32'h0, cyc, hold);
    check("seq34_pre_hi", hi, 32'hAAAA_5555);
    @(negedge clk);
    start = 1'b1; op = 3'd2; src_a = 32'd100; src_b = 32'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("seq34_rst_busy", {31'b0, busy}, 32'h0);
    check("seq34_rst_hi", hi, 32'h0);
    check("seq34_rst_lo", lo, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    n = 0;
    repeat (12) begin
      @(negedge clk);
      if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) n++;
    end
    check("seq34_no_late_write", 32'(n), 32'h0);

    // first start is taken at the first edge after release
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    start = 1'b1; op = 3'd5; src_a = 32'h0000_5A5A;
    @(negedge clk);
    start = 1'b0;
    check("seq26_first_start_lo", lo, 32'h0000_5A5A);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  // global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 MULT_CYCLES, default 5: busy duration in cycles for mult/multu.
REQ-002 DIV_CYCLES, default 10: busy duration in cycles for div/divu.
REQ-003 clk  input  1: single clock; all state changes on rising edge.
REQ-004 rst  input  1: asynchronous, active-low reset.
REQ-005 start  input  1: op valid this cycle (EX stage issues an md instruction).
REQ-006 op  input  3: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO; other codes are no-ops.
REQ-007 src_a  input  32: rs operand, taken from register-file read port 1 after forwarding.
REQ-008 src_b  input  32: rt operand, taken from register-file read port 2 after forwarding.
REQ-009 busy  output  1: registered; high while a mult/div is in flight.
REQ-010 hi  output  32: HI register, consumed by mfhi on the register-file write path.
REQ-011 lo  output  32: LO register, consumed by mflo on the register-file write path.

Function
REQ-012 The block SHALL have two states, IDLE and BUSY, with busy=1 exactly in BUSY.
REQ-013 IDLE + start + mult/div op at edge k SHALL latch the operands, compute the result into internal shadow registers, load the down-counter with N (MULT_CYCLES or DIV_CYCLES), and enter BUSY.
REQ-014 busy SHALL be high for exactly N cycles after edge k; at edge k+N, hi/lo SHALL take the shadow result and the state SHALL return to IDLE with busy=0.
REQ-015 hi/lo SHALL hold their previous values throughout BUSY; no partial results are visible.
REQ-016 start while BUSY SHALL be ignored, because the pipeline stalls on (start & md op) | busy.
REQ-017 MTHI/MTLO in IDLE with start SHALL write src_a to hi/lo at the next edge, with no BUSY phase.
REQ-018 MULT SHALL compute the signed 32x32 -> 64 product; MULTU SHALL compute the unsigned product; {hi,lo}={upper,lower}.
REQ-019 DIV/DIVU SHALL set lo=quotient and hi=remainder; signed quotient truncates toward zero and the remainder takes the dividend's sign.
REQ-020 Division by zero (src_b=0) SHALL still run DIV_CYCLES, and hi/lo SHALL stay unchanged at completion.
REQ-021 DIV 0x80000000 / 0xFFFFFFFF SHALL yield lo=0x80000000, hi=0.
REQ-022 The down-counter SHALL be wide enough for max(MULT_CYCLES, DIV_CYCLES) and SHALL never wrap; at 1 it completes on the next edge.
REQ-023 Undefined op codes with start SHALL leave state, hi, lo and busy unchanged.

Reset
REQ-024 rst=0 SHALL immediately force IDLE, busy=0, hi=0, lo=0, counter=0 and clear the shadow registers, independent of clk.
REQ-025 Reset asserted mid-operation SHALL abort the operation; no result is ever written after release.
REQ-026 The first start is accepted at the first rising edge after rst goes high.

Structure
REQ-027 The op-code constants (MD_*) SHALL be defined in define_file.v, shared with the decoder and the stall logic.
REQ-028 Arithmetic SHALL be done with behavioural operators at issue; only the latency counter is sequential.
REQ-029 No sub-module is required; the counter and FSM are written inline.

Verification
REQ-030 MULT src_a=0xFFFFFFFE, src_b=3 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-031 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> after 5 cycles hi=0xFFFFFFFE, lo=0x00000001.
REQ-032 DIV -7/2 -> busy high 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/0 -> hi/lo unchanged after 10 cycles.
REQ-033 MTHI 0x12345678, then in the next cycle MULT starts with MTLO asserted during BUSY -> hi reads 0x12345678 until the MULT completes; the MTLO is ignored.
REQ-034 rst pulsed low at cycle 3 of a DIV -> busy=0 and hi=lo=0 immediately; no update occurs after 10 cycles.
